// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 / exception unit.
//   mode_t       : processor mode state (USER, HANDLER, HALT)
//   CAUSE_*      : 3-bit exception cause codes held in the Cause register
//   C0_*         : CP0 register select values (instruction rd field)
package cp0_pkg;

  typedef enum logic [1:0] {
    USER    = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } mode_t;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_OVF  = 3'd1;
  localparam logic [2:0] CAUSE_PRIV = 3'd2;
  localparam logic [2:0] CAUSE_ILL  = 3'd3;
  localparam logic [2:0] CAUSE_IRQ  = 3'd4;

  localparam logic [4:0] C0_COUNT  = 5'd9;
  localparam logic [4:0] C0_STATUS = 5'd12;
  localparam logic [4:0] C0_CAUSE  = 5'd13;
  localparam logic [4:0] C0_EPC    = 5'd14;

endpackage

// File: rtl/cp0_unit_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two destination clocks of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values,
      // giving a true two-stage chain rather than a single wire.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 / exception unit.
// Holds Status.IE, Cause, EPC and a saturating exception counter, runs the
// USER/HANDLER/HALT mode machine and drives PC redirect / kill signals for
// the single-cycle datapath.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   pc                     : address of the executing instruction
//   int_cause, cause_write : decoder exception cause and request
//   exit_kernel, write_c0  : exk and movc0 instructions
//   c0_sel, wd             : CP0 register select and movc0 write data
//   irq                    : asynchronous external interrupt (level)
//   rdata                  : CP0 register read data (combinational)
//   kernel_mode            : 1 in USER mode (privileged ops trap)
//   exc_redirect           : take exception now, next PC = VECTOR
//   eret_redirect          : leave handler now, next PC = EPC
//   redirect_pc            : VECTOR or EPC
//   instr_kill             : suppress writes of the current instruction
//   halt                   : double fault, core stops fetching
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] VECTOR = WIDTH'(32'h0000_0180),
  parameter int               CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       int_cause,
  input  logic             cause_write,
  input  logic             exit_kernel,
  input  logic             write_c0,
  input  logic [4:0]       c0_sel,
  input  logic [WIDTH-1:0] wd,
  input  logic             irq,
  output logic [WIDTH-1:0] rdata,
  output logic             kernel_mode,
  output logic             exc_redirect,
  output logic             eret_redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             instr_kill,
  output logic             halt
);

  mode_t            state;
  logic             ie;
  logic [2:0]       cause;
  logic [WIDTH-1:0] epc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             irq_s;
  logic             irq_req;
  logic             exc_req;
  logic [2:0]       eff_cause;

  sync2 u_irq_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (irq),
    .q     (irq_s)
  );

  // A decoder exception always wins over the interrupt; the interrupt is
  // only taken from user mode with IE set.
  assign irq_req   = irq_s & ie & (state == USER) & ~cause_write;
  assign exc_req   = cause_write | irq_req;
  assign eff_cause = cause_write ? int_cause : CAUSE_IRQ;
  assign count_next = (count == '1) ? count : count + CNT_W'(1);

  assign kernel_mode   = (state == USER);
  assign exc_redirect  = exc_req & (state != HALT);
  assign eret_redirect = exit_kernel & (state == HANDLER) & ~exc_req;
  assign redirect_pc   = exc_redirect ? VECTOR : epc;
  assign instr_kill    = exc_redirect | halt;

  always_comb begin
    // NOTE: default assignment first so no select path leaves rdata
    // unassigned, which would otherwise infer a latch.
    rdata = '0;
    case (c0_sel)
      C0_STATUS: begin
        rdata[0] = (state == USER);
        rdata[1] = ie;
      end
      C0_CAUSE: begin
        rdata[2:0]       = cause;
        rdata[WIDTH-1]   = irq_s;
      end
      C0_EPC:   rdata = epc;
      C0_COUNT: rdata = WIDTH'(count);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HANDLER;
      ie    <= 1'b0;
      cause <= CAUSE_NONE;
      epc   <= '0;
      count <= '0;
      halt  <= 1'b0;
    end else begin
      case (state)
        USER: begin
          // exit_kernel and write_c0 arriving here without an exception
          // are not legal in user mode and are ignored.
          if (exc_req) begin
            state <= HANDLER;
            epc   <= pc;
            cause <= eff_cause;
            count <= count_next;
          end
        end
        HANDLER: begin
          if (exc_req) begin
            // Fault inside the handler: keep EPC pointing at the original
            // faulting instruction and stop for good.
            state <= HALT;
            cause <= eff_cause;
            count <= count_next;
            halt  <= 1'b1;
          end else begin
            if (exit_kernel) state <= USER;
            if (write_c0) begin
              case (c0_sel)
                C0_STATUS: ie  <= wd[1];
                C0_EPC:    epc <= wd;
                default:   ;
              endcase
            end
          end
        end
        default: ; // HALT is absorbing until reset
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge.
module tb_cp0_unit;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [2:0]  int_cause;
  logic        cause_write;
  logic        exit_kernel;
  logic        write_c0;
  logic [4:0]  c0_sel;
  logic [31:0] wd;
  logic        irq;
  logic [31:0] rdata;
  logic        kernel_mode;
  logic        exc_redirect;
  logic        eret_redirect;
  logic [31:0] redirect_pc;
  logic        instr_kill;
  logic        halt;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  cp0_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .int_cause     (int_cause),
    .cause_write   (cause_write),
    .exit_kernel   (exit_kernel),
    .write_c0      (write_c0),
    .c0_sel        (c0_sel),
    .wd            (wd),
    .irq           (irq),
    .rdata         (rdata),
    .kernel_mode   (kernel_mode),
    .exc_redirect  (exc_redirect),
    .eret_redirect (eret_redirect),
    .redirect_pc   (redirect_pc),
    .instr_kill    (instr_kill),
    .halt          (halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one full cycle, ending just after the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    int_cause   = 3'd0;
    cause_write = 1'b0;
    exit_kernel = 1'b0;
    write_c0    = 1'b0;
    wd          = '0;
  endtask

  task automatic rd(input logic [4:0] sel, input string tag, input logic [31:0] exp);
    c0_sel = sel;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    pc    = '0;
    irq   = 1'b0;
    c0_sel = '0;
    idle();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // Reset state
    #1;
    check("rst_kernel_mode", 32'(kernel_mode), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    rd(C0_STATUS, "rst_status", 32'd0);
    rd(C0_EPC, "rst_epc", 32'd0);
    rd(C0_COUNT, "rst_count", 32'd0);
    cyc();

    // Handler enables IE, then exk at pc=0x40 back to user at EPC=0
    write_c0 = 1'b1; c0_sel = C0_STATUS; wd = 32'd2;
    cyc();
    idle();
    rd(C0_STATUS, "status_ie_set", 32'd2);
    pc = 32'h40; exit_kernel = 1'b1;
    #1;
    check("exk_eret", 32'(eret_redirect), 32'd1);
    check("exk_redirect_pc", redirect_pc, 32'd0);
    check("exk_no_exc", 32'(exc_redirect), 32'd0);
    check("exk_no_kill", 32'(instr_kill), 32'd0);
    cyc();
    idle();
    #1;
    check("user_kernel_mode", 32'(kernel_mode), 32'd1);
    rd(C0_STATUS, "status_user", 32'd3);
    cyc();

    // Overflow exception from user at pc=0x100
    pc = 32'h100; cause_write = 1'b1; int_cause = CAUSE_OVF;
    #1;
    check("ovf_exc_redirect", 32'(exc_redirect), 32'd1);
    check("ovf_kill", 32'(instr_kill), 32'd1);
    check("ovf_redirect_pc", redirect_pc, 32'h180);
    check("ovf_no_eret", 32'(eret_redirect), 32'd0);
    cyc();
    idle();
    rd(C0_EPC, "ovf_epc", 32'h100);
    rd(C0_CAUSE, "ovf_cause", 32'd1);
    rd(C0_COUNT, "ovf_count", 32'd1);
    check("ovf_kernel_mode", 32'(kernel_mode), 32'd0);
    cyc();

    // Handler rewrites EPC, exk returns there
    write_c0 = 1'b1; c0_sel = C0_EPC; wd = 32'h200;
    cyc();
    idle();
    rd(C0_EPC, "epc_write", 32'h200);
    rd(5'd3, "unmapped_sel", 32'd0);
    exit_kernel = 1'b1;
    #1;
    check("exk2_redirect_pc", redirect_pc, 32'h200);
    cyc();
    idle();

    // Interrupt with IE=1 while in user at pc=0x300
    pc = 32'h300; irq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1;
      if (exc_redirect) seen = 1'b1;
      else cyc();
    end
    check("irq_taken", 32'(seen), 32'd1);
    check("irq_redirect_pc", redirect_pc, 32'h180);
    check("irq_kill", 32'(instr_kill), 32'd1);
    irq = 1'b0;
    cyc();
    rd(C0_EPC, "irq_epc", 32'h300);
    rd(C0_CAUSE, "irq_cause_raw", 32'h8000_0004);
    rd(C0_COUNT, "irq_count", 32'd2);
    cyc();
    rd(C0_CAUSE, "irq_cause_clear", 32'd4);
    cyc();

    // Same interrupt with IE=0 must be ignored
    write_c0 = 1'b1; c0_sel = C0_STATUS; wd = 32'd0;
    cyc();
    idle();
    exit_kernel = 1'b1;
    cyc();
    idle();
    irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("irq_masked", 32'(exc_redirect), 32'd0);
      cyc();
    end
    irq = 1'b0;
    #1;
    check("irq_masked_user", 32'(kernel_mode), 32'd1);
    cyc(); cyc(); cyc();

    // Privileged fault at pc=0x400, then double fault with a movc0 to EPC
    pc = 32'h400; cause_write = 1'b1; int_cause = CAUSE_PRIV;
    cyc();
    idle();
    pc = 32'h500; cause_write = 1'b1; int_cause = CAUSE_ILL;
    write_c0 = 1'b1; c0_sel = C0_EPC; wd = 32'hABC;
    #1;
    check("dbl_exc_redirect", 32'(exc_redirect), 32'd1);
    cyc();
    idle();
    #1;
    check("dbl_halt", 32'(halt), 32'd1);
    check("dbl_kernel_mode", 32'(kernel_mode), 32'd0);
    rd(C0_EPC, "dbl_epc_kept", 32'h400);
    rd(C0_CAUSE, "dbl_cause", 32'd3);
    rd(C0_COUNT, "dbl_count", 32'd4);
    cyc();
    for (int i = 0; i < 3; i++) begin
      cause_write = 1'b1; int_cause = CAUSE_OVF; exit_kernel = 1'b1;
      write_c0 = 1'b1; c0_sel = C0_EPC; wd = 32'h777;
      #1;
      check("halt_no_exc", 32'(exc_redirect), 32'd0);
      check("halt_no_eret", 32'(eret_redirect), 32'd0);
      check("halt_kill", 32'(instr_kill), 32'd1);
      cyc();
    end
    idle();
    rd(C0_EPC, "halt_epc_frozen", 32'h400);
    rd(C0_COUNT, "halt_count_frozen", 32'd4);

    // Reset recovers from HALT
    reset = 1'b0;
    #1;
    check("rec_halt", 32'(halt), 32'd0);
    rd(C0_EPC, "rec_epc", 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // 300 exceptions with exk between each: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      exit_kernel = 1'b1;
      cyc();
      idle();
      pc = 32'h600; cause_write = 1'b1; int_cause = CAUSE_OVF;
      cyc();
      idle();
    end
    rd(C0_COUNT, "sat_count", 32'd255);
    rd(C0_EPC, "sat_epc", 32'h600);
    check("sat_kernel_mode", 32'(kernel_mode), 32'd0);

    // Asynchronous reset mid-handler, away from any clock edge
    #2;
    reset = 1'b0;
    #1;
    rd(C0_COUNT, "async_count", 32'd0);
    rd(C0_EPC, "async_epc", 32'd0);
    rd(C0_CAUSE, "async_cause", 32'd0);
    rd(C0_STATUS, "async_status", 32'd0);
    check("async_kernel_mode", 32'(kernel_mode), 32'd0);
    check("async_halt", 32'(halt), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 / exception unit sitting directly downstream of the main decoder. Consumes int_cause, cause_write, exit_kernel and write_c0; produces kernel_mode back to the decoder.
- Holds Status, Cause, EPC and an exception counter. Runs a mode state machine (USER/HANDLER/HALT) and synchronises one external interrupt.
- Drives the PC-redirect and instruction-kill signals used by the single-cycle datapath.

Parameters:
WIDTH, 32, datapath/PC width
VECTOR, 32'h0000_0180, handler entry address
CNT_W, 8, exception counter width (saturating)

Ports:
clk  in  1  clock (rising edge)
reset  in  1  asynchronous, active-low reset
pc  in  WIDTH  address of the instruction currently executing
int_cause  in  3  decoder cause: 0 none, 1 overflow, 2 privileged in user mode, 3 illegal
cause_write  in  1  decoder exception request
exit_kernel  in  1  exk instruction
write_c0  in  1  movc0 instruction
c0_sel  in  5  CP0 register select (instruction rd field)
wd  in  WIDTH  write data for movc0
irq  in  1  asynchronous external interrupt, level, active-high
rdata  out  WIDTH  CP0 register read for movrf
kernel_mode  out  1  1 = user mode (privileged ops trap); 0 = handler mode
exc_redirect  out  1  comb.: take exception this cycle, next PC = VECTOR
eret_redirect  out  1  comb.: exit handler this cycle, next PC = EPC
redirect_pc  out  WIDTH  comb.: VECTOR or EPC per redirect
instr_kill  out  1  comb.: suppress regwrite/memwrite of current instruction
halt  out  1  double fault; core must stop fetching

Behaviour:
- Reset (reset=0, async):
  - state=HANDLER, so kernel_mode=0 (boot runs privileged).
  - Status.IE=0, Cause=0, EPC=0, count=0, irq sync flops=0, halt=0.
- irq passes through a 2-flop synchroniser; irq_s is its output, 2–3 cycle latency.
- Exception request exc_req:
  - cause_write=1, or
  - irq_s & IE & state==USER & !cause_write, with effective cause 3'b100.
- Priority, same cycle: cause_write > irq > exit_kernel > write_c0.
- Combinational outputs, same cycle as the instruction:
  - exc_redirect = exc_req & state!=HALT
  - eret_redirect = exit_kernel & state==HANDLER & !exc_req
  - redirect_pc = exc_redirect ? VECTOR : EPC
  - instr_kill = exc_redirect | halt
- State machine (registered, rising edge):
  - USER: exc_req -> HANDLER; EPC<=pc; Cause<=effective cause; count+=1 (saturate at all-ones).
  - HANDLER: exc_req -> HALT; Cause<=effective cause; EPC unchanged; count+=1 (saturating); halt<=1.
  - HANDLER: exit_kernel without exc_req -> USER.
  - HALT: absorbing until reset. All redirects 0, instr_kill=1, no register writes.
- kernel_mode = (state==USER). In HALT it is 0.
- CP0 register map (c0_sel):
  - 12 Status: bit0 = user-mode flag (read-only, mirrors state), bit1 = IE (writable), other bits read 0.
  - 13 Cause: bits[2:0] cause, bit31 = irq_s raw; read-only.
  - 14 EPC: read/write.
  - 9 Count: zero-extended; read-only.
  - Any other select reads 0; writes to it are ignored.
- movc0 write: takes effect when write_c0 & state==HANDLER & !exc_req. A write in the same cycle as an exception is dropped.
- rdata is combinational from current register values. A write lands at the clock edge and is visible the following cycle.
- exit_kernel in USER never reaches this unit as legal; the decoder flags it as cause 2. If exit_kernel arrives alone, it is ignored.
- Reset asserted mid-handler: immediate return to the reset values above.

Decomposition:
- Shared package cp0_pkg:
  - typedef enum mode_t {USER, HANDLER, HALT}
  - cause codes CAUSE_NONE/OVF/PRIV/ILL/IRQ (3-bit)
  - register select constants C0_STATUS=12, C0_CAUSE=13, C0_EPC=14, C0_COUNT=9
- One sub-module: sync2, a 2-flop synchroniser with async active-low reset, reused for irq.

Test Plan:
- Reset release, then read Status/EPC/Count -> kernel_mode=0, Status=0, EPC=0, Count=0, halt=0.
- Handler writes Status=2 (IE) and issues exk at pc=0x40 -> eret_redirect=1, redirect_pc=0 (EPC), next cycle kernel_mode=1.
- In USER, pc=0x100, cause_write=1, int_cause=1 -> same cycle exc_redirect=1, instr_kill=1, redirect_pc=0x180; next cycle EPC=0x100, Cause=1, Count=1, kernel_mode=0.
- In USER with IE=1, pulse irq -> within 3 cycles exc_redirect=1, EPC=pc at that cycle, Cause=4. Repeat with IE=0 -> no redirect.
- In HANDLER, cause_write=1 (int_cause=3) together with write_c0 to EPC=0xABC -> EPC unchanged, halt=1 next cycle, all later redirects 0 and instr_kill=1 until reset.
- Force 300 exceptions (exk between each) -> Count saturates at 255; assert reset mid-handler -> all registers return to reset values asynchronously.
